// File: rtl/key_debounce_pulse_if.sv
// Button conditioner bus: raw buttons in; debounced levels, step pulses and their OR out.
// master is the conditioner side, slave is the consumer/driver side.
interface key_debounce_pulse_if #(
    parameter int CHANNELS = 5
);
    logic [CHANNELS-1:0] Button;
    logic [CHANNELS-1:0] Level;
    logic [CHANNELS-1:0] Pulse;
    logic                AnyPulse;

    modport master (input Button, output Level, Pulse, AnyPulse);
    modport slave  (output Button, input Level, Pulse, AnyPulse);
endinterface

// File: rtl/key_debounce_pulse.sv
// Multi-channel pushbutton sync/debounce with edge and hold-to-repeat step pulses.
// Latency: Level 1+DEBOUNCE_CYCLES edges after first sample, Pulse one edge later; no backpressure.
module key_debounce_pulse #(
    parameter int CHANNELS        = 5,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                   BasysCLK,
    input  logic                   Reset_n,
    key_debounce_pulse_if.master   bus
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    localparam bit PULSE_RISE = (EDGE_MODE == 1) || (EDGE_MODE == 2);
    localparam bit PULSE_FALL = (EDGE_MODE == 0) || (EDGE_MODE == 2);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d_q;
    logic [CHANNELS-1:0] level_nxt;
    logic [CHANNELS-1:0] pulse_q;
    logic [CHANNELS-1:0] edge_fire;
    logic [CHANNELS-1:0] rpt_fire;

    logic [CNT_W-1:0] cnt_q   [CHANNELS];
    logic [CNT_W-1:0] cnt_nxt [CHANNELS];

    rpt_state_e       state_q   [CHANNELS];
    rpt_state_e       state_nxt [CHANNELS];
    logic [TMR_W-1:0] tmr_q     [CHANNELS];
    logic [TMR_W-1:0] tmr_nxt   [CHANNELS];

    // Any sample matching the accepted level restarts the stability window.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i]   = '0;
            level_nxt[i] = level_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_nxt[i] = sync2_q[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign edge_fire = (level_q & ~level_d_q & {CHANNELS{PULSE_RISE}})
                     | (~level_q & level_d_q & {CHANNELS{PULSE_FALL}});

    always_ff @(posedge BasysCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            level_d_q <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= bus.Button;
            sync2_q   <= sync1_q;
            level_q   <= level_nxt;
            level_d_q <= level_q;
            pulse_q   <= edge_fire | rpt_fire;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
        end
    end

    // Repeat FSM: the press is seen the same cycle the edge pulse is generated, so the
    // first repeat lands REPEAT_DELAY cycles after the press pulse. A pending fall
    // (level_nxt low) already aborts, so no repeat coincides with the release.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_nxt[i] = state_q[i];
            tmr_nxt[i]   = tmr_q[i];
            rpt_fire[i]  = 1'b0;
            if ((REPEAT_EN == 0) || !level_q[i] || !level_nxt[i]) begin
                state_nxt[i] = RPT_IDLE;
                tmr_nxt[i]   = '0;
            end else begin
                case (state_q[i])
                    RPT_IDLE: begin
                        if (!level_d_q[i]) begin
                            state_nxt[i] = RPT_DELAY;
                            tmr_nxt[i]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (tmr_q[i] == DELAY_LAST) begin
                            state_nxt[i] = RPT_REPEAT;
                            tmr_nxt[i]   = '0;
                            rpt_fire[i]  = 1'b1;
                        end else begin
                            tmr_nxt[i] = tmr_q[i] + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (tmr_q[i] == PERIOD_LAST) begin
                            tmr_nxt[i]  = '0;
                            rpt_fire[i] = 1'b1;
                        end else begin
                            tmr_nxt[i] = tmr_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt[i] = RPT_IDLE;
                        tmr_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge BasysCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= RPT_IDLE;
                tmr_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_nxt[i];
                tmr_q[i]   <= tmr_nxt[i];
            end
        end
    end

    assign bus.Level    = level_q;
    assign bus.Pulse    = pulse_q;
    assign bus.AnyPulse = |pulse_q;

endmodule
